// File: rtl/div_unit.sv
// RV32 integer divide unit (DIV, DIVU, REM, REMU).
// Restoring radix-2 divider on operand magnitudes: 32 iterations in CALC,
// then sign correction in FIX. Divide-by-zero and signed overflow bypass
// the iterations and go straight to DONE with the architectural result.
// The result is held in a register so it is stable for the whole DONE cycle.
module div_unit (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  rd_in,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        we,
    output logic [4:0]  rd,
    output logic [31:0] wd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] wd_q, wd_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    // Operand decode: op[0]=0 means signed, op[1]=1 means remainder.
    logic        op_signed;
    logic        op_rem;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        sgn_ovf;
    logic [31:0] fast_res;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    logic [32:0] shifted;
    logic [32:0] trial;

    // Sign-corrected results used in FIX.
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes, special-case detection and the per-iteration datapath.
    always_comb begin
        op_signed = ~op[0];
        op_rem    = op[1];
        a_neg     = op_signed & dividend[31];
        b_neg     = op_signed & divisor[31];
        a_mag     = a_neg ? (~dividend + 32'd1) : dividend;
        b_mag     = b_neg ? (~divisor + 32'd1) : divisor;
        div_zero  = (divisor == 32'd0);
        sgn_ovf   = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        if (div_zero) begin
            fast_res = op_rem ? dividend : 32'hFFFF_FFFF;
        end else begin
            fast_res = op_rem ? 32'd0 : 32'h8000_0000;
        end
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, dvsr_q};
        quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end

    // Next-state and datapath next values; every _d defaults to its _q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        wd_d      = wd_q;
        rd_d      = rd_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d      = rd_in;
                    is_rem_d  = op_rem;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = 5'd0;
                    rem_d     = 32'd0;
                    quo_d     = a_mag;
                    dvsr_d    = b_mag;
                    if (div_zero || sgn_ovf) begin
                        wd_d    = fast_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Dividend bits shift out of quo_q's top as quotient bits shift in.
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                wd_d    = is_rem_q ? rem_fix : quo_fix;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and captured-request registers.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            wd_q      <= 32'd0;
            rd_q      <= 5'd0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            wd_q      <= wd_d;
            rd_q      <= rd_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign we   = done & (|rd_q);
    assign rd   = rd_q;
    assign wd   = wd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed expected results.
module tb_div_unit;

    logic        CLK;
    logic        RST_X;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  rd_in;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    int checks;
    int failures;

    div_unit dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .start    (start),
        .op       (op),
        .rd_in    (rd_in),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .we       (we),
        .rd       (rd),
        .wd       (wd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request; optionally inject an ignored start at cycle inject_at.
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [4:0] rd_v,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_wd, input int exp_lat, input int inject_at);
        int lat;
        int busy_cnt;
        logic [31:0] wd_seen;
        logic [4:0]  rd_seen;
        logic        we_seen;
        logic        got_done;
        @(negedge CLK);
        start    = 1'b1;
        op       = op_v;
        rd_in    = rd_v;
        dividend = a;
        divisor  = b;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        got_done = 1'b0;
        wd_seen  = 32'd0;
        rd_seen  = 5'd0;
        we_seen  = 1'b0;
        while (!got_done && lat < 60) begin
            @(negedge CLK);
            lat++;
            if (busy) busy_cnt++;
            if (lat == 1) check_eq({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
            if (inject_at > 0 && lat == inject_at) begin
                start    = 1'b1;
                op       = OP_DIVU;
                rd_in    = 5'd4;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else if (inject_at > 0 && lat == inject_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                wd_seen  = wd;
                rd_seen  = rd;
                we_seen  = we;
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check_eq({tag, "_wd"}, wd_seen, exp_wd);
        check_eq({tag, "_rd"}, {27'd0, rd_seen}, {27'd0, rd_v});
        check_eq({tag, "_we"}, {31'd0, we_seen}, {31'd0, (rd_v != 5'd0)});
        @(negedge CLK);
        check_eq({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        $display("txn %s op=%0d a=0x%08h b=0x%08h wd=0x%08h rd=%0d we=%0b lat=%0d",
                 tag, op_v, a, b, wd_seen, rd_seen, we_seen, lat);
    endtask

    initial begin
        int evt;
        checks   = 0;
        failures = 0;
        RST_X    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        rd_in    = 5'd0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_rd", {27'd0, rd}, 32'd0);
        check_eq("rst_wd", wd, 32'd0);
        $display("txn reset busy=%0b done=%0b rd=%0d wd=0x%08h", busy, done, rd, wd);
        RST_X = 1'b1;

        run_op("divu_100_7", OP_DIVU, 5'd5, 32'd100, 32'd7, 32'd14, 34, 0);
        run_op("remu_100_7", OP_REMU, 5'd5, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op("div_m7_2", OP_DIV, 5'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem_m7_2", OP_REM, 5'd7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("div_7_m2", OP_DIV, 5'd8, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0);
        run_op("rem_7_m2", OP_REM, 5'd9, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0);
        run_op("divu_big", OP_DIVU, 5'd10, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 0);
        run_op("div_5_0", OP_DIV, 5'd11, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("remu_5_0", OP_REMU, 5'd12, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op("div_ovf", OP_DIV, 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", OP_REM, 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run_op("divu_ovf_pat", OP_DIVU, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0);
        run_op("ignored_start", OP_DIVU, 5'd3, 32'd100, 32'd7, 32'd14, 34, 5);
        run_op("rd_zero", OP_DIVU, 5'd0, 32'd100, 32'd7, 32'd14, 34, 0);

        // Abort at CALC iteration 10; a start held during reset must be ignored.
        @(negedge CLK);
        start    = 1'b1;
        op       = OP_DIVU;
        rd_in    = 5'd5;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (11) @(negedge CLK);
        RST_X    = 1'b0;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge CLK);
        RST_X = 1'b1;
        start = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_rd", {27'd0, rd}, 32'd0);
        check_eq("abort_wd", wd, 32'd0);
        evt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done || we || busy) evt++;
        end
        check_eq("abort_no_done", evt, 32'd0);
        $display("txn abort_mid_calc busy=%0b events=%0d", busy, evt);
        run_op("divu_8_2", OP_DIVU, 5'd6, 32'd8, 32'd2, 32'd4, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
